cordic_req_seq: RTL and testbench
=================================

CORDIC_REQ_SEQ -- requirements
Module: cordic_req_seq

Interface
REQ-001 SHALL have parameters:
- WIDTH, 32: operand and result width (Q16.16).
- TIMEOUT, 64: maximum WAIT cycles before the request is aborted.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_op, in, 3: 0 SIN, 1 COS, 2 MULT, 3 DIV, 4 SINH, 5 COSH.
- req_a, in, WIDTH: signed Q16.16; angle (SIN/COS/SINH/COSH), multiplicand (MULT) or divisor (DIV).
- req_b, in, WIDTH: signed Q16.16; multiplier (MULT) or dividend (DIV); ignored otherwise.
- cordic_enable, out, 1: one-cycle launch pulse to the CORDIC core.
- cordic_operation, out, 3: op code to the core.
- cordic_x / cordic_y / cordic_z, out, WIDTH: core operands.
- cordic_result, in, WIDTH: core result.
- cordic_done, in, 1: core completion.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: response consumed when rsp_valid && rsp_ready.
- rsp_data, out, WIDTH: signed Q16.16 result.
- rsp_err, out, 1: request rejected or timed out.

Function
REQ-003 SHALL implement FSM states IDLE, PREP, LAUNCH, WAIT, POST, RESP, with one transition per clock at most.
REQ-004 SHALL drive req_ready = (state==IDLE) && !rst, and SHALL accept a request only in IDLE, capturing req_op, req_a and req_b.
REQ-005 IDLE->PREP on accept; PREP computes operands and checks errors.
- No error: PREP->LAUNCH.
- Error: PREP->RESP with rsp_err=1, rsp_data=0, and no cordic_enable.
REQ-006 SHALL flag as errors:
- req_op 6 or 7.
- SIN/COS with |a| > 205887 (pi).
- DIV with a == 0.
- SINH/COSH with |a| > 73282 (1.1182).
REQ-007 SIN/COS range reduction (negate flag neg):
- a > 102944 (pi/2): z = 205887 - a.
- a < -102944: z = -205887 - a.
- Otherwise: z = a.
- neg = 1 only for COS when reduced; SIN is never negated.
REQ-008 Operand presets:
- SIN/COS: x = 39797 (1/K), y = 0.
- MULT: x = a, y = 0, z = b.
- DIV: x = a, y = b, z = 0.
- SINH/COSH: x = 79134 (1/Kh), y = 0, z = a.
- cordic_operation = req_op in all cases.
REQ-009 LAUNCH SHALL assert cordic_enable for exactly one cycle, then go to WAIT.
REQ-010 cordic_x/y/z/operation SHALL be held stable from LAUNCH until leaving WAIT.
REQ-011 WAIT SHALL count cycles from 0.
- cordic_done==1: capture cordic_result, go to POST.
- Count reaches TIMEOUT-1 without done: go to RESP with rsp_err=1, rsp_data=0.
REQ-012 cordic_done SHALL be ignored in every state except WAIT.
REQ-013 POST SHALL set rsp_data = neg ? -result : result (two's complement, WIDTH bits, wrap), rsp_err=0, then go to RESP.
REQ-014 RESP SHALL assert rsp_valid with rsp_data and rsp_err stable until rsp_ready==1; it then returns to IDLE the next cycle with rsp_valid=0.
REQ-015 Latency SHALL be:
- Accept to cordic_enable: 2 cycles.
- cordic_done to rsp_valid: 2 cycles.
- Error in PREP: rsp_valid 2 cycles after accept.
REQ-016 At most one request SHALL be outstanding; no request is accepted between accept and the rsp handshake.

Reset
REQ-017 With rst==1 at a clock edge, the block SHALL enter IDLE and clear:
- Outputs: cordic_enable, cordic_operation, cordic_x/y/z, rsp_valid, rsp_data, rsp_err.
- Internals: neg, timeout counter, captured operands.
REQ-018 Reset SHALL take priority over every transition, including mid-WAIT and mid-RESP.
- Any in-flight request is dropped with no response.
- A cordic_done arriving after reset SHALL be ignored.
REQ-019 req_ready SHALL be 0 while rst==1 and 1 on the first cycle after rst deasserts.

Verification
REQ-020 The bench SHALL cover these scenarios (core model returns sin/cos/product/quotient/sinh/cosh after 18 cycles):
- SIN, a=154415 (3pi/4) -> cordic_z=51472, rsp_data=46341+/-64, rsp_err=0.
- COS, a=154415 -> cordic_z=51472, rsp_data=-46341+/-64, rsp_err=0.
- DIV, a=0, b=983040 -> no cordic_enable, rsp_valid 2 cycles after accept, rsp_err=1, rsp_data=0.
- MULT, a=98304, b=131072, cordic_done never asserted -> rsp_err=1 after 64 WAIT cycles.
- SINH, a=65536, rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data (77018+/-64) stable, req_ready=0, a second req_valid not accepted until the handshake completes.
- rst pulsed during WAIT, cordic_done asserted 3 cycles later -> all outputs 0, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/cordic_req_seq.sv
// Request/response sequencer in front of a multi-function CORDIC core.
// Range-reduces and presets operands, launches the core, waits with timeout, and returns one result.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// PREP   | operand presets, range reduction and error screening
// LAUNCH | cordic_enable high for this single cycle
// WAIT   | operands held, waiting for cordic_done or timeout
// POST   | apply result sign correction
// RESP   | rsp_valid held until rsp_ready
module cordic_req_seq #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             cordic_enable,
    output logic [2:0]       cordic_operation,
    output logic [WIDTH-1:0] cordic_x,
    output logic [WIDTH-1:0] cordic_y,
    output logic [WIDTH-1:0] cordic_z,
    input  logic [WIDTH-1:0] cordic_result,
    input  logic             cordic_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_SIN  = 3'd0;
    localparam logic [2:0] OP_COS  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SINH = 3'd4;
    localparam logic [2:0] OP_COSH = 3'd5;

    // Q16.16 constants: pi, pi/2, 1/K, 1/Kh and the hyperbolic convergence limit
    localparam logic signed [WIDTH-1:0] LP_PI     = WIDTH'(205887);
    localparam logic signed [WIDTH-1:0] LP_NPI    = WIDTH'(-205887);
    localparam logic signed [WIDTH-1:0] LP_HPI    = WIDTH'(102944);
    localparam logic signed [WIDTH-1:0] LP_NHPI   = WIDTH'(-102944);
    localparam logic signed [WIDTH-1:0] LP_INV_K  = WIDTH'(39797);
    localparam logic signed [WIDTH-1:0] LP_INV_KH = WIDTH'(79134);
    localparam logic signed [WIDTH-1:0] LP_HMAX   = WIDTH'(73282);
    localparam logic signed [WIDTH-1:0] LP_NHMAX  = WIDTH'(-73282);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_LAUNCH,
        S_WAIT,
        S_POST,
        S_RESP
    } state_t;

    state_t                   r_state;
    logic [2:0]               r_op;
    logic signed [WIDTH-1:0]  r_a;
    logic signed [WIDTH-1:0]  r_b;
    logic                     r_neg;
    logic [CW-1:0]            r_cnt;
    logic [WIDTH-1:0]         r_result;

    logic                     w_err;
    logic                     w_neg;
    logic signed [WIDTH-1:0]  w_x;
    logic signed [WIDTH-1:0]  w_y;
    logic signed [WIDTH-1:0]  w_z;

    assign req_ready = (r_state == S_IDLE) && !rst;

    always_comb begin
        w_err = 1'b0;
        w_neg = 1'b0;
        w_x   = '0;
        w_y   = '0;
        w_z   = '0;
        case (r_op)
            OP_SIN, OP_COS: begin
                w_err = (r_a > LP_PI) || (r_a < LP_NPI);
                w_x   = LP_INV_K;
                // Fold into [-pi/2, pi/2]; only cosine changes sign under the fold
                if (r_a > LP_HPI) begin
                    w_z   = LP_PI - r_a;
                    w_neg = (r_op == OP_COS);
                end else if (r_a < LP_NHPI) begin
                    w_z   = LP_NPI - r_a;
                    w_neg = (r_op == OP_COS);
                end else begin
                    w_z   = r_a;
                end
            end
            OP_MULT: begin
                w_x = r_a;
                w_z = r_b;
            end
            OP_DIV: begin
                w_err = (r_a == '0);
                w_x   = r_a;
                w_y   = r_b;
            end
            OP_SINH, OP_COSH: begin
                w_err = (r_a > LP_HMAX) || (r_a < LP_NHMAX);
                w_x   = LP_INV_KH;
                w_z   = r_a;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_op             <= '0;
            r_a              <= '0;
            r_b              <= '0;
            r_neg            <= 1'b0;
            r_cnt            <= '0;
            r_result         <= '0;
            cordic_enable    <= 1'b0;
            cordic_operation <= '0;
            cordic_x         <= '0;
            cordic_y         <= '0;
            cordic_z         <= '0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (w_err) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        r_state   <= S_RESP;
                    end else begin
                        cordic_operation <= r_op;
                        cordic_x         <= w_x;
                        cordic_y         <= w_y;
                        cordic_z         <= w_z;
                        r_neg            <= w_neg;
                        cordic_enable    <= 1'b1;
                        r_state          <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cordic_enable <= 1'b0;
                    r_cnt         <= '0;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        r_result <= cordic_result;
                        r_state  <= S_POST;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_POST: begin
                    rsp_data  <= r_neg ? (-r_result) : r_result;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_req_seq.sv
// Directed bench for cordic_req_seq with a behavioural CORDIC core answering 18 cycles after launch.
module tb_cordic_req_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        cordic_enable;
    logic [2:0]  cordic_operation;
    logic [31:0] cordic_x, cordic_y, cordic_z;
    logic [31:0] cordic_result;
    logic        cordic_done;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        core_on = 1'b1;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_res = '0;
    int          mdl_cnt = 0;
    logic        tb_done = 1'b0;
    logic [31:0] tb_res = '0;
    int          en_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    assign cordic_done   = mdl_done | tb_done;
    assign cordic_result = tb_done ? tb_res : mdl_res;

    cordic_req_seq #(.WIDTH(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .cordic_enable(cordic_enable), .cordic_operation(cordic_operation),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z),
        .cordic_result(cordic_result), .cordic_done(cordic_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] core_fn(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] z);
        real    zr;
        longint p;
        zr = $itor($signed(z)) / 65536.0;
        p  = 0;
        case (op)
            3'd0: p = longint'($rtoi($sin(zr) * 65536.0));
            3'd1: p = longint'($rtoi($cos(zr) * 65536.0));
            3'd2: p = (longint'($signed(x)) * longint'($signed(z))) >>> 16;
            3'd3: if (x != 0) p = (longint'($signed(y)) * 65536) / longint'($signed(x));
            3'd4: p = longint'($rtoi($sinh(zr) * 65536.0));
            3'd5: p = longint'($rtoi($cosh(zr) * 65536.0));
            default: p = 0;
        endcase
        return p[31:0];
    endfunction

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (cordic_enable) en_cnt <= en_cnt + 1;
        if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_done <= 1'b1;
        end else if (cordic_enable && core_on) begin
            mdl_cnt <= 18;
            mdl_res <= core_fn(cordic_operation, cordic_x, cordic_y, cordic_z);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return cordic_enable;
            1: return rsp_valid;
            2: return cordic_done;
            3: return req_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int s, input int max, output int n);
        n = 0;
        while (!sig(s) && n < max) begin
            tick();
            n++;
        end
        if (!sig(s)) chk($sformatf("wait_bound_sig%0d", s), 0, 1);
    endtask

    task automatic send(input logic [2:0] op, input int a, input int b);
        int n;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        wait_sig(3, 100, n);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ack_valid_low", rsp_valid, 0);
    endtask

    task automatic do_row(input string tag, input logic [2:0] op, input int a, input int b,
                          input logic exp_err, input int exp_z, input int exp_data, input int tol);
        int n, e0;
        e0 = en_cnt;
        send(op, a, b);
        n = 0;
        while (!cordic_enable && !rsp_valid && n < 10) begin
            tick();
            n++;
        end
        if (cordic_enable && !exp_err) chk({tag, "_z"}, $signed(cordic_z), exp_z);
        wait_sig(1, 200, n);
        chk({tag, "_err"}, rsp_err, exp_err);
        chk({tag, "_data"}, $signed(rsp_data), exp_data, tol);
        chk({tag, "_en"}, en_cnt - e0, exp_err ? 0 : 1);
        ack();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e0;

        // Reset state
        #1;
        chk("rst_ready_low", req_ready, 0);
        tick(); tick();
        chk("rst_enable", cordic_enable, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_x", cordic_x, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", req_ready, 1);
        tick();

        // SIN 3pi/4 folds to pi/4
        send(3'd0, 154415, 0);
        wait_sig(0, 10, n);
        chk("sin_acc2en", n + 1, 2);
        chk("sin_z", $signed(cordic_z), 51472);
        chk("sin_x", cordic_x, 39797);
        chk("sin_y", cordic_y, 0);
        chk("sin_op", cordic_operation, 0);
        tick();
        chk("sin_en_pulse", cordic_enable, 0);
        wait_sig(2, 100, n);
        chk("sin_z_hold", $signed(cordic_z), 51472);
        wait_sig(1, 10, n);
        chk("sin_done2rsp", n, 2);
        chk("sin_data", $signed(rsp_data), 46341, 64);
        chk("sin_err", rsp_err, 0);
        ack();
        chk("sin_ready_after", req_ready, 1);

        // COS 3pi/4 -> negated cos(pi/4)
        send(3'd1, 154415, 0);
        wait_sig(0, 10, n);
        chk("cos_z", $signed(cordic_z), 51472);
        chk("cos_op", cordic_operation, 1);
        wait_sig(1, 100, n);
        chk("cos_data", $signed(rsp_data), -46341, 64);
        chk("cos_err", rsp_err, 0);
        ack();

        // DIV by zero rejected in PREP
        e0 = en_cnt;
        send(3'd3, 0, 983040);
        wait_sig(1, 10, n);
        chk("div0_lat", n + 1, 2);
        chk("div0_err", rsp_err, 1);
        chk("div0_data", rsp_data, 0);
        chk("div0_no_en", en_cnt - e0, 0);
        ack();

        // MULT with a silent core: timeout after 64 WAIT cycles
        core_on = 1'b0;
        send(3'd2, 98304, 131072);
        wait_sig(0, 10, n);
        chk("mult_x", $signed(cordic_x), 98304);
        chk("mult_y", cordic_y, 0);
        chk("mult_z", $signed(cordic_z), 131072);
        wait_sig(1, 200, n);
        chk("mult_to_cycles", n, 65);
        chk("mult_to_err", rsp_err, 1);
        chk("mult_to_data", rsp_data, 0);
        ack();
        core_on = 1'b1;

        // SINH with back-pressure and a competing request
        e0 = en_cnt;
        send(3'd4, 65536, 0);
        wait_sig(1, 100, n);
        req_op = 3'd0; req_a = 0; req_b = 0; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("sinh_valid", rsp_valid, 1);
            chk("sinh_data", $signed(rsp_data), 77018, 64);
            chk("sinh_ready", req_ready, 0);
            tick();
        end
        chk("sinh_one_launch", en_cnt - e0, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("sinh_valid_drop", rsp_valid, 0);
        chk("sinh_ready_back", req_ready, 1);
        tick();
        req_valid = 1'b0;
        wait_sig(1, 100, n);
        chk("second_data", $signed(rsp_data), 0, 64);
        chk("second_launch", en_cnt - e0, 2);
        ack();

        // Boundary and error table
        do_row("op6",        3'd6, 0, 0, 1'b1, 0, 0, 0);
        do_row("sin_gt_pi",  3'd0, 205888, 0, 1'b1, 0, 0, 0);
        do_row("cos_lt_npi", 3'd1, -205888, 0, 1'b1, 0, 0, 0);
        do_row("sinh_big",   3'd4, 73283, 0, 1'b1, 0, 0, 0);
        do_row("cosh_nbig",  3'd5, -73283, 0, 1'b1, 0, 0, 0);
        do_row("sin_pi",     3'd0, 205887, 0, 1'b0, 0, 0, 64);
        do_row("cos_nfold",  3'd1, -102945, 0, 1'b0, -102942, 0, 64);
        do_row("cos_hpi",    3'd1, 102944, 0, 1'b0, 102944, 0, 64);
        do_row("mult",       3'd2, 98304, 131072, 1'b0, 131072, 196608, 0);
        do_row("div",        3'd3, 131072, 983040, 1'b0, 0, 491520, 0);
        do_row("cosh",       3'd5, -65536, 0, 1'b0, -65536, 101127, 64);

        // Reset mid-WAIT, late cordic_done must be ignored
        core_on = 1'b0;
        e0 = en_cnt;
        send(3'd2, 98304, 131072);
        wait_sig(0, 10, n);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mrst_ready_low", req_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_ready", req_ready, 1);
        chk("mrst_en", cordic_enable, 0);
        chk("mrst_op", cordic_operation, 0);
        chk("mrst_x", cordic_x, 0);
        chk("mrst_y", cordic_y, 0);
        chk("mrst_z", cordic_z, 0);
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_data", rsp_data, 0);
        chk("mrst_err", rsp_err, 0);
        tick(); tick(); tick();
        tb_res  = 32'd12345;
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("late_done_valid", rsp_valid, 0);
            chk("late_done_ready", req_ready, 1);
            chk("late_done_data", rsp_data, 0);
            tick();
        end
        chk("late_done_no_launch", en_cnt - e0, 1);
        core_on = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
